adc_scan_mux: RTL
=================

Name: adc_scan_mux

Overview:
- Autonomous multi-channel scanner for the on-board ADC128S022 SPI converter, which has 8 inputs and 12-bit resolution.
- Replaces the static, hard-wired ADC/analog-mux hookup at top level.
- Sequences channel addresses, drives the serial frame and deserialises results into per-channel 16-bit words.
- Results feed the MCU data_in_flat bus and read back as data inputs, with no MCU involvement per sample.

Parameters:
- NUM_CHANNELS, 8: channels scanned, 0..NUM_CHANNELS-1. Legal range 1..8.
- CLK_DIV, 13: sysclk cycles per SCLK half-period (H). Minimum 8, so SCLK ≤ 3.2 MHz at 50 MHz.
- RESULT_FLAT_WIDTH, NUM_CHANNELS*16: width of the results bus.

Ports:
- sysclk  in  1  system clock, 50 MHz.
- sysreset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = scan continuously.
- busy  out  1  1 while a scan is in progress.
- scan_done  out  1  one-sysclk pulse after the last channel of a scan is stored.
- results_flat  out  RESULT_FLAT_WIDTH  channel i at bits [i*16+15:i*16], format {4'b0, sample[11:0]}.
- result_valid  out  NUM_CHANNELS  bit i set once channel i has been written since reset.
- adc_cs_n  out  1  ADC chip select.
- adc_saddr  out  1  ADC DIN (address).
- adc_sclk  out  1  ADC serial clock; idles high.
- adc_sdat  in  1  ADC DOUT.

Behaviour:
- Reset values (asynchronous, immediate, including mid-frame):
  - adc_cs_n=1, adc_sclk=1, adc_saddr=0.
  - busy=0, scan_done=0.
  - results_flat=0, result_valid=0.
  - state=IDLE, all counters=0.
- Interface: sysclk and sysreset; one clock domain. adc_sdat is double-flopped before use.
- Frame = one CS-low period of 16 SCLK cycles.
  - Frame f (f=0..NUM_CHANNELS) sends the address of channel (f mod NUM_CHANNELS).
  - The ADC returns the conversion addressed in the previous frame, so frame f (f≥1) data is stored to channel f-1.
  - Frame 0 data is discarded (priming frame).
  - A scan is therefore NUM_CHANNELS+1 frames.
- State machine:
  - IDLE: if run=1 → SETUP with frame=0, busy=1.
  - SETUP: adc_cs_n=0, hold H cycles → SCLK_LO with bit=0.
  - SCLK_LO: adc_sclk=0 for H cycles.
    - On entry, adc_saddr = address bit. Bits 2,3,4 carry ADD2,ADD1,ADD0; all other bits are 0.
    - Then → SCLK_HI.
  - SCLK_HI: adc_sclk=1 for H cycles.
    - On entry, sample synced adc_sdat into the shift register if bit ≥ 4, MSB first.
    - If bit=15 → STORE; else bit+1 → SCLK_LO.
  - STORE (1 cycle): adc_cs_n=1.
    - If frame ≥ 1, write the channel word and set its result_valid bit.
    - If frame=NUM_CHANNELS, pulse scan_done → GAP_END; else → GAP.
  - GAP: adc_cs_n=1 for 2H cycles, frame+1 → SETUP.
  - GAP_END: adc_cs_n=1 for 2H cycles.
    - If run=1 → SETUP with frame=0.
    - Else → IDLE, busy=0.
- Frame length is exactly 35H+1 sysclk cycles; a scan is (NUM_CHANNELS+1)*(35H+1).
- A result word is updated atomically in the STORE cycle. Other channels hold their values.
- Deasserting run mid-scan does not abort: the scan completes with all channels stored, then goes idle.
- Asserting run during GAP_END continues seamlessly.
- NUM_CHANNELS=1: frame 0 primes ch0, frame 1 reads ch0 and also addresses ch0.
- Bits 0..3 of DOUT are ignored, not checked.

Optional Feature:
- Macro: ADC_SCAN_AVG_EN.
- When defined:
  - Each channel has a 14-bit accumulator.
  - Every scan adds the new 12-bit sample to the accumulator.
  - Every 4th scan the stored word becomes {4'b0, acc[13:2]}, the accumulator clears, and result_valid is set then.
  - scan_done pulses only on the scans that update results_flat.
  - Accumulators reset to 0 on sysreset.
- When undefined: each scan overwrites results directly; no accumulators are synthesised.

Test Plan:
- Reset mid-frame: assert sysreset during SCLK_LO of frame 2 → same cycle adc_cs_n=1, adc_sclk=1, results_flat=0, result_valid=0, busy=0.
- Single scan: NUM_CHANNELS=8, CLK_DIV=13, ADC model returning 0x100+ch. Pulse run for one cycle → 9 frames, each 456 sysclk cycles. Addresses seen are 0,1,…,7,0. results ch0..7 = 0x0100..0x0107; result_valid=0xFF; scan_done pulses once; busy falls 2H after the last STORE.
- Address encoding: frame addressing ch5 → adc_saddr high on falling edges 2 and 4 and low on edge 3 (101), low elsewhere.
- Continuous run: run held high for 3 scans with a model value changing per scan → scan_done every 9*456 cycles. Words track the latest scan; no frame-0 data ever stored (model returns 0xFFF in priming frames; it never appears).
- run dropped mid-scan (during frame 4) → frames 5..8 complete, all 8 channels updated, then IDLE.
- ADC_SCAN_AVG_EN, NUM_CHANNELS=2: model ch0 returns 100,200,300,400 over 4 scans → results ch0 = 0x00FA (250) after scan 4 only. Earlier scans leave results 0, valid=0, and produce no scan_done.

Source files
------------

// File: rtl/adc_scan_mux.sv
// adc_scan_mux: free-running ADC128S022 channel scanner producing one 16-bit word per channel.
// Define ADC_SCAN_AVG_EN to publish the mean of every 4 scans instead of each raw sample.
module adc_scan_mux #(
   parameter int NUM_CHANNELS      = 8,
   parameter int CLK_DIV           = 13,
   parameter int RESULT_FLAT_WIDTH = NUM_CHANNELS*16
) (
   input  logic                         sysclk,
   input  logic                         sysreset,
   input  logic                         run,
   output logic                         busy,
   output logic                         scan_done,
   output logic [RESULT_FLAT_WIDTH-1:0] results_flat,
   output logic [NUM_CHANNELS-1:0]      result_valid,
   output logic                         adc_cs_n,
   output logic                         adc_saddr,
   output logic                         adc_sclk,
   input  logic                         adc_sdat
);
   localparam int              CNTW       = $clog2(2*CLK_DIV);
   localparam logic [CNTW-1:0] HALF_LAST  = CNTW'(CLK_DIV-1);
   localparam logic [CNTW-1:0] GAP_LAST   = CNTW'(2*CLK_DIV-1);
   localparam logic [3:0]      LAST_FRAME = 4'(NUM_CHANNELS);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      SCLK_LO = 3'd2,
      SCLK_HI = 3'd3,
      STORE   = 3'd4,
      GAP     = 3'd5,
      GAP_END = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        frame_q, frame_d;
   logic [11:0]       shift_q, shift_d;
   logic              sdat_meta_q, sdat_sync_q;
   logic              cs_n_q, cs_n_d, sclk_q, sclk_d, saddr_q, saddr_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [15:0]       res_q [NUM_CHANNELS];
   logic [15:0]       res_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] valid_q, valid_d;
   logic              store_en_s;
   logic [3:0]        store_ch_s;
   logic [2:0]        addr_s;
`ifdef ADC_SCAN_AVG_EN
   logic [13:0]       acc_q [NUM_CHANNELS];
   logic [13:0]       acc_d [NUM_CHANNELS];
   logic [1:0]        scan_cnt_q, scan_cnt_d;
`endif

   // DIN carries ADD2..ADD0 on bits 2..4 of the frame, zero elsewhere
   function automatic logic addr_bit(input logic [3:0] bit_idx, input logic [2:0] addr);
      case (bit_idx)
         4'd2:    addr_bit = addr[2];
         4'd3:    addr_bit = addr[1];
         4'd4:    addr_bit = addr[0];
         default: addr_bit = 1'b0;
      endcase
   endfunction

   // The last frame of a scan re-addresses channel 0 while it reads back the final channel
   assign addr_s     = (frame_q == LAST_FRAME) ? 3'd0 : frame_q[2:0];
   assign store_ch_s = frame_q - 4'd1;

   // Frame sequencer: next state, counters and next values of the serial pins
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNTW'(1);
      bit_cnt_d  = bit_cnt_q;
      frame_d    = frame_q;
      shift_d    = shift_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      store_en_s = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (run) begin
               state_d = SETUP;
               frame_d = 4'd0;
               busy_d  = 1'b1;
            end else begin
               busy_d  = 1'b0;
            end
         end
         SETUP: begin
            if (cnt_q == HALF_LAST) begin
               state_d   = SCLK_LO;
               cnt_d     = '0;
               bit_cnt_d = 4'd0;
            end else begin
               state_d   = SETUP;
            end
         end
         SCLK_LO: begin
            if (cnt_q == HALF_LAST) begin
               state_d = SCLK_HI;
               cnt_d   = '0;
               if (bit_cnt_q >= 4'd4) begin
                  shift_d = {shift_q[10:0], sdat_sync_q};
               end else begin
                  shift_d = shift_q;
               end
            end else begin
               state_d = SCLK_LO;
            end
         end
         SCLK_HI: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (bit_cnt_q == 4'd15) begin
                  state_d = STORE;
               end else begin
                  state_d   = SCLK_LO;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               state_d = SCLK_HI;
            end
         end
         STORE: begin
            cnt_d      = '0;
            store_en_s = (frame_q != 4'd0);
            if (frame_q == LAST_FRAME) begin
               state_d = GAP_END;
`ifdef ADC_SCAN_AVG_EN
               done_d  = (scan_cnt_q == 2'd3);
`else
               done_d  = 1'b1;
`endif
            end else begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = SETUP;
               cnt_d   = '0;
               frame_d = frame_q + 4'd1;
            end else begin
               state_d = GAP;
            end
         end
         GAP_END: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (run) begin
                  state_d = SETUP;
                  frame_d = 4'd0;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               state_d = GAP_END;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
      cs_n_d  = !(state_d == SETUP || state_d == SCLK_LO || state_d == SCLK_HI);
      sclk_d  = (state_d != SCLK_LO);
      saddr_d = (state_d == SCLK_LO || state_d == SCLK_HI) ? addr_bit(bit_cnt_d, addr_s) : 1'b0;
   end

   // Result words: each channel word changes only in its own STORE cycle
   always_comb begin
      res_d   = res_q;
      valid_d = valid_q;
`ifdef ADC_SCAN_AVG_EN
      acc_d = acc_q;
      if (state_q == STORE && frame_q == LAST_FRAME) begin
         scan_cnt_d = scan_cnt_q + 2'd1;
      end else begin
         scan_cnt_d = scan_cnt_q;
      end
`endif
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (store_en_s && store_ch_s == 4'(i)) begin
`ifdef ADC_SCAN_AVG_EN
            acc_d[i] = acc_q[i] + {2'b00, shift_q};
            if (scan_cnt_q == 2'd3) begin
               res_d[i]   = {4'h0, acc_d[i][13:2]};
               acc_d[i]   = 14'd0;
               valid_d[i] = 1'b1;
            end else begin
               res_d[i]   = res_q[i];
            end
`else
            res_d[i]   = {4'h0, shift_q};
            valid_d[i] = 1'b1;
`endif
         end else begin
            res_d[i] = res_q[i];
         end
      end
   end

   // State, datapath and registered outputs; reset acts immediately, even mid-frame
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= 4'd0;
         frame_q     <= 4'd0;
         shift_q     <= 12'h000;
         sdat_meta_q <= 1'b0;
         sdat_sync_q <= 1'b0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b1;
         saddr_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_q       <= '{default: 16'h0000};
         valid_q     <= '0;
`ifdef ADC_SCAN_AVG_EN
         acc_q       <= '{default: 14'd0};
         scan_cnt_q  <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_q     <= frame_d;
         shift_q     <= shift_d;
         sdat_meta_q <= adc_sdat;
         sdat_sync_q <= sdat_meta_q;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         saddr_q     <= saddr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         res_q       <= res_d;
         valid_q     <= valid_d;
`ifdef ADC_SCAN_AVG_EN
         acc_q       <= acc_d;
         scan_cnt_q  <= scan_cnt_d;
`endif
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_flat
      assign results_flat[g*16 +: 16] = res_q[g];
   end

   assign busy         = busy_q;
   assign scan_done    = done_q;
   assign result_valid = valid_q;
   assign adc_cs_n     = cs_n_q;
   assign adc_sclk     = sclk_q;
   assign adc_saddr    = saddr_q;
endmodule
